// File: rtl/note_seq_pkg.sv
// Shared types and defaults for the note-address sequencer.
// Holds the playback state encoding and the default beat prescaler length.
package note_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } note_state_e;

  // 125 ms per beat at a 100 MHz system clock
  localparam int unsigned DEFAULT_TICK_CYCLES = 32'd12500000;

endpackage

// File: rtl/note_sequencer_if.sv
// Control/ROM/tone-side signal bundle of the note sequencer.
// The master is the control FSM plus note ROM; the slave is the sequencer.
interface note_sequencer_if
  import note_seq_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DUR_W  = 4
);

  // start/pause/stop/loop_en are levels sampled on every clock edge (no
  // handshake); priority is stop > pause > start. rom_dur is a combinational
  // read of the ROM at note_addr. tick and song_done are one-cycle pulses.
  logic              start;
  logic              pause;
  logic              stop;
  logic              loop_en;
  logic [DUR_W-1:0]  rom_dur;
  logic [ADDR_W-1:0] note_addr;
  logic              note_valid;
  logic              tick;
  logic              song_done;
  logic              playing;
  note_state_e       dbg_state;

  modport master (
    output start, pause, stop, loop_en, rom_dur,
    input  note_addr, note_valid, tick, song_done, playing, dbg_state
  );

  modport slave (
    input  start, pause, stop, loop_en, rom_dur,
    output note_addr, note_valid, tick, song_done, playing, dbg_state
  );

endinterface

// File: rtl/tick_divider.sv
// Beat prescaler: counts enabled cycles 0..TICK_CYCLES-1 and pulses tick on
// the last count. Freezes when en is low; clr returns the count to zero.
module tick_divider
  import note_seq_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = DEFAULT_TICK_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_CYCLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TICK_CYCLES - 1);

  logic [CNT_W-1:0] tick_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (clr) begin
      tick_cnt <= '0;
    end else if (en) begin
      tick_cnt <= (tick_cnt == LAST_CNT) ? '0 : tick_cnt + 1'b1;
    end
  end

  // Gated by en so a frozen count parked on LAST_CNT never pulses
  assign tick = en && (tick_cnt == LAST_CNT);

endmodule

// File: rtl/note_sequencer.sv
// Note-address sequencer: steps the note-ROM address once per note duration
// (in beats), with start/pause/stop control, end-of-song pulse and looping.
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = DEFAULT_TICK_CYCLES,
  parameter int          ADDR_W      = 8,
  parameter int          SONG_LEN    = 256,
  parameter int          DUR_W       = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  note_sequencer_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);

  note_state_e       state_q, state_d;
  logic [DUR_W-1:0]  beat_cnt;
  logic [ADDR_W-1:0] note_addr;
  logic [DUR_W-1:0]  dur_m1;
  logic              tick;
  logic              div_en;
  logic              div_clr;
  logic              note_end;
  logic              at_last;
  logic              song_done;

  // Pause and stop both mask the divider so a pending tick is swallowed
  assign div_en  = (state_q == ST_PLAY) && !bus.stop && !bus.pause;
  assign div_clr = bus.stop || (state_q == ST_IDLE) || (state_q == ST_DONE);

  tick_divider #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick_divider (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (div_en),
    .clr    (div_clr),
    .tick   (tick)
  );

  assign dur_m1   = (bus.rom_dur == '0) ? '0 : bus.rom_dur - 1'b1;
  assign note_end = tick && (beat_cnt == dur_m1);
  assign at_last  = (note_addr == LAST_ADDR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    song_done = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
        end else if (bus.start && !bus.pause) begin
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
        end else if (bus.pause) begin
          state_d = ST_PAUSED;
        end else if (note_end && at_last) begin
          song_done = 1'b1;
          if (!bus.loop_en) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_PAUSED: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
        end else if (bus.start && !bus.pause) begin
          state_d = ST_PLAY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The last note wraps the address to 0, which also serves the DONE case
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_cnt  <= '0;
      note_addr <= '0;
    end else if (div_clr) begin
      beat_cnt  <= '0;
      note_addr <= '0;
    end else if (tick) begin
      if (note_end) begin
        beat_cnt  <= '0;
        note_addr <= at_last ? '0 : note_addr + 1'b1;
      end else begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  assign bus.note_addr  = note_addr;
  assign bus.note_valid = (state_q == ST_PLAY) || (state_q == ST_PAUSED);
  assign bus.playing    = (state_q == ST_PLAY);
  assign bus.tick       = tick;
  assign bus.song_done  = song_done;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: a song-level reference model predicts every beat
// (cycle, address, end-of-song) and a monitor checks each tick against it.
module tb_note_sequencer;

  localparam int TICK     = 4;
  localparam int SONG_LEN = 3;
  localparam int ADDR_W   = 8;
  localparam int DUR_W    = 4;
  localparam int W        = 43;

  logic clk;
  logic reset_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [DUR_W-1:0] rom [256];
  logic [W-1:0] exp_q[$];

  note_sequencer_if #(.ADDR_W(ADDR_W), .DUR_W(DUR_W)) bus ();

  note_sequencer #(
    .TICK_CYCLES(TICK),
    .ADDR_W     (ADDR_W),
    .SONG_LEN   (SONG_LEN),
    .DUR_W      (DUR_W)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  assign bus.rom_dur = rom[bus.note_addr];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: each note lasts max(dur,1) beats, one beat per TICK
  // cycles starting TICK-1 cycles after the start edge; song end on the
  // last beat of the last note.
  task automatic push_song(input int e, input int shift, input int passes, input int max_ticks);
    int k = 0;
    for (int p = 0; p < passes; p++) begin
      for (int i = 0; i < SONG_LEN; i++) begin
        int d = (rom[i] == 0) ? 1 : int'(rom[i]);
        for (int b = 0; b < d; b++) begin
          if (k < max_ticks) begin
            exp_q.push_back({32'(e + TICK - 1 + k * TICK + shift), 8'(i),
                             (i == SONG_LEN - 1) && (b == d - 1), 1'b1, 1'b1});
          end
          k++;
        end
      end
    end
  endtask

  // driver tasks
  task automatic start_song(output int e);
    @(posedge clk); #1;
    bus.start = 1'b1;
    e = cyc + 1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    @(posedge clk); #1;
    bus.stop = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic play(input bit lp);
    int e;
    bus.loop_en = lp;
    start_song(e);
    push_song(e, 0, lp ? 2 : 1, 1000);
    wait_drain(400);
    if (lp) begin
      chk("loop_playing", 64'(bus.playing), 64'd1);
      pulse_stop();
    end else begin
      repeat (2) @(posedge clk);
      #1;
    end
    chk("end_valid", 64'(bus.note_valid), 64'd0);
    chk("end_playing", 64'(bus.playing), 64'd0);
    chk("end_addr", 64'(bus.note_addr), 64'd0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset_n && (bus.tick || bus.song_done)) begin
      logic [W-1:0] act;
      act = {32'(cyc), bus.note_addr, bus.song_done, bus.tick, bus.playing};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tick actual %0h expected none", act);
      end else begin
        chk("tick_event", 64'(act), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int e;
    for (int i = 0; i < 256; i++) rom[i] = '0;
    reset_n     = 1'b0;
    bus.start   = 1'b0;
    bus.pause   = 1'b0;
    bus.stop    = 1'b0;
    bus.loop_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr", 64'(bus.note_addr), 64'd0);
    chk("rst_valid", 64'(bus.note_valid), 64'd0);
    chk("rst_tick", 64'(bus.tick), 64'd0);
    chk("rst_done", 64'(bus.song_done), 64'd0);
    chk("rst_playing", 64'(bus.playing), 64'd0);
    reset_n = 1'b1;

    // basic song, then looping, then zero duration on note 1
    rom[0] = 4'd1; rom[1] = 4'd2; rom[2] = 4'd1;
    play(1'b0);
    play(1'b1);
    rom[0] = 4'd1; rom[1] = 4'd0; rom[2] = 4'd2;
    play(1'b0);

    // pause in the cycle a tick would fire, held frozen for 10 cycles
    rom[0] = 4'd2; rom[1] = 4'd1; rom[2] = 4'd1;
    bus.loop_en = 1'b0;
    start_song(e);
    push_song(e, 11, 1, 1000);
    repeat (3) @(posedge clk);
    #1;
    bus.pause = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("pause_playing", 64'(bus.playing), 64'd0);
    chk("pause_valid", 64'(bus.note_valid), 64'd1);
    chk("pause_addr", 64'(bus.note_addr), 64'd0);
    bus.pause = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("resume_playing", 64'(bus.playing), 64'd1);
    wait_drain(200);
    repeat (2) @(posedge clk);
    #1;
    chk("pause_song_end", 64'(bus.note_valid), 64'd0);

    // stop together with pause and start mid-song
    rom[0] = 4'd2; rom[1] = 4'd2; rom[2] = 4'd2;
    start_song(e);
    push_song(e, 0, 1, 3);
    repeat (12) @(posedge clk);
    #1;
    chk("pre_stop_addr", 64'(bus.note_addr), 64'd1);
    bus.stop = 1'b1; bus.pause = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.stop = 1'b0; bus.pause = 1'b0; bus.start = 1'b0;
    chk("stop_addr", 64'(bus.note_addr), 64'd0);
    chk("stop_playing", 64'(bus.playing), 64'd0);
    chk("stop_valid", 64'(bus.note_valid), 64'd0);
    wait_drain(10);

    // randomized songs
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < SONG_LEN; i++) rom[i] = 4'($urandom_range(0, 3));
      play(1'($urandom_range(0, 1)));
    end

    // asynchronous reset mid-note
    rom[0] = 4'd3; rom[1] = 4'd1; rom[2] = 4'd1;
    start_song(e);
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_playing", 64'(bus.playing), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_addr", 64'(bus.note_addr), 64'd0);
    chk("arst_valid", 64'(bus.note_valid), 64'd0);
    chk("arst_playing", 64'(bus.playing), 64'd0);
    chk("arst_tick", 64'(bus.tick), 64'd0);
    chk("arst_done", 64'(bus.song_done), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_playing", 64'(bus.playing), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
